rd_data_buf: RTL and testbench

- Parametrised single-clock read-return buffer for the DDR2 controller read path.
- Captures data beats returned by the PHY/read capture logic and stores them.
- Presents them first-word-fall-through with a valid/ready handshake.
- Provides programmable threshold flags, a burst-room credit for the read scheduler, beat-accurate end-of-burst marking, and sticky overflow detection.

---
 rtl/rd_data_buf_pkg.sv | 26 ++
 rtl/rd_data_buf_if.sv | 34 +++
 rtl/rd_data_buf_ram.sv | 21 ++
 rtl/rd_data_buf.sv | 112 +++++++++++
 tb/tb_rd_data_buf.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rd_data_buf_pkg.sv
// Shared constants and elaboration helpers for the DDR2 read-return buffer.
package ddr2_rd_pkg;

  localparam int DEF_DATA_WIDTH  = 128;
  localparam int DEF_WRITE_BURST = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Buffer must hold two whole bursts and thresholds must sit inside the count range.
  function automatic bit params_ok(input int depth, input int burst,
                                   input int af, input int ae);
    return is_pow2(depth) && is_pow2(burst) && (burst >= 2) &&
           (depth >= 2 * burst) && (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae < af);
  endfunction

endpackage

// File: rtl/rd_data_buf_if.sv
// Read-return bus: PHY beat input, FWFT consumer handshake, status flags.
interface rd_data_buf_if
  import ddr2_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_W      = 7
);
  logic [DATA_WIDTH-1:0] rd_fifo_in;
  logic                  rd_fifo_vd;
  logic                  rd_en;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] rd_fifo_out;
  logic                  fifo_out_vd;
  logic                  fifo_out_last;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic                  burst_room;
  logic [CNT_W-1:0]      data_count;
  logic                  overflow;

  modport slave (
    input  rd_fifo_in, rd_fifo_vd, rd_en, ovf_clr,
    output rd_fifo_out, fifo_out_vd, fifo_out_last, full, almost_full,
           empty, almost_empty, burst_room, data_count, overflow
  );

  modport master (
    output rd_fifo_in, rd_fifo_vd, rd_en, ovf_clr,
    input  rd_fifo_out, fifo_out_vd, fifo_out_last, full, almost_full,
           empty, almost_empty, burst_room, data_count, overflow
  );
endinterface

// File: rtl/rd_data_buf_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module rdb_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 129,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rd_data_buf.sv
// DDR2 read-return buffer: FWFT output register in front of a distributed RAM,
// with registered level flags, burst-room credit and burst-last framing.
module rd_data_buf
  import ddr2_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = 64,
  parameter int WRITE_BURST = DEF_WRITE_BURST,
  parameter int AF_THRESH   = 48,
  parameter int AE_THRESH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  rd_data_buf_if.slave bus
);
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int AW    = clog2(DEPTH);
  localparam int BW    = clog2(WRITE_BURST);
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] L_AE    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] L_ROOM  = CNT_W'(DEPTH - WRITE_BURST);
  localparam logic [BW-1:0]    L_LAST  = BW'(WRITE_BURST - 1);

  if (!params_ok(DEPTH, WRITE_BURST, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("rd_data_buf: illegal DEPTH/WRITE_BURST/threshold combination");
  end

  logic [AW-1:0]         r_wptr, r_rptr;
  logic [BW-1:0]         r_wbeat;
  logic [CNT_W-1:0]      r_mem_cnt, r_count;
  logic                  r_out_vd, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_full, r_af, r_empty, r_ae, r_room, r_ovf;

  logic                  w_push, w_pop, w_load, w_out_vd_next, w_wr_last;
  logic [CNT_W-1:0]      w_mem_cnt_next, w_count_next;
  logic [DATA_WIDTH:0]   w_rd_word;

  rdb_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata ({w_wr_last, bus.rd_fifo_in}),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_word)
  );

  // Acceptance looks only at the registered full, so a same-cycle pop cannot save a beat.
  assign w_push         = bus.rd_fifo_vd & ~r_full;
  assign w_pop          = r_out_vd & bus.rd_en;
  assign w_load         = (r_mem_cnt != '0) & (~r_out_vd | w_pop);
  assign w_wr_last      = (r_wbeat == L_LAST);
  assign w_mem_cnt_next = r_mem_cnt + CNT_W'(w_push) - CNT_W'(w_load);
  assign w_out_vd_next  = w_load | (r_out_vd & ~w_pop);
  assign w_count_next   = w_mem_cnt_next + CNT_W'(w_out_vd_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wbeat    <= '0;
      r_mem_cnt  <= '0;
      r_count    <= '0;
      r_out_vd   <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
      r_full     <= 1'b0;
      r_af       <= 1'b0;
      r_empty    <= 1'b1;
      r_ae       <= 1'b1;
      r_room     <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + AW'(1);
        r_wbeat <= r_wbeat + BW'(1);
      end
      if (w_load) begin
        r_rptr     <= r_rptr + AW'(1);
        r_out_data <= w_rd_word[DATA_WIDTH-1:0];
        r_out_last <= w_rd_word[DATA_WIDTH];
      end
      r_out_vd  <= w_out_vd_next;
      r_mem_cnt <= w_mem_cnt_next;
      r_count   <= w_count_next;
      // Flags track next-state count so they line up with data_count.
      r_full    <= (w_count_next == L_DEPTH);
      r_af      <= (w_count_next >= L_AF);
      r_empty   <= (w_count_next == '0);
      r_ae      <= (w_count_next <= L_AE);
      r_room    <= (w_count_next <= L_ROOM);
      if (bus.rd_fifo_vd & r_full) r_ovf <= 1'b1;
      else if (bus.ovf_clr)        r_ovf <= 1'b0;
    end
  end

  assign bus.rd_fifo_out   = r_out_data;
  assign bus.fifo_out_vd   = r_out_vd;
  assign bus.fifo_out_last = r_out_last;
  assign bus.full          = r_full;
  assign bus.almost_full   = r_af;
  assign bus.empty         = r_empty;
  assign bus.almost_empty  = r_ae;
  assign bus.burst_room    = r_room;
  assign bus.data_count    = r_count;
  assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_rd_data_buf.sv
// Self-checking bench for rd_data_buf: directed tables plus random traffic against a queue model.
module tb_rd_data_buf;
  localparam int DW = 128, DEPTH = 16, WB = 8, AF = 12, AE = 2, CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rd_data_buf_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  rd_data_buf #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .WRITE_BURST(WB),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model: every stored beat in arrival order, tagged with the edge that accepted it.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
    logic          last;
  } beat_t;
  beat_t mq[$];
  int    cyc = 0;
  int    nacc = 0;
  logic  movf = 1'b0;
  int    checks = 0;
  int    errors = 0;

  typedef struct {
    logic       vd, re, clr;
    logic [4:0] cnt;
    logic       full, af, br, ovf;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    bit vis;
    n   = mq.size();
    vis = (n > 0) && (mq[0].t < cyc);
    chk("data_count",   bus.data_count,   n);
    chk("empty",        bus.empty,        n == 0);
    chk("full",         bus.full,         n == DEPTH);
    chk("almost_full",  bus.almost_full,  n >= AF);
    chk("almost_empty", bus.almost_empty, n <= AE);
    chk("burst_room",   bus.burst_room,   (DEPTH - n) >= WB);
    chk("overflow",     bus.overflow,     movf);
    chk("fifo_out_vd",  bus.fifo_out_vd,  vis);
    if (vis) begin
      chk("rd_fifo_out",   bus.rd_fifo_out,   mq[0].d);
      chk("fifo_out_last", bus.fifo_out_last, mq[0].last);
    end
  endtask

  task automatic step(input logic vd, input logic re, input logic clr, input logic [DW-1:0] d);
    bit vis, mfull;
    bus.rd_fifo_vd = vd;
    bus.rd_en      = re;
    bus.ovf_clr    = clr;
    bus.rd_fifo_in = d;
    vis   = (mq.size() > 0) && (mq[0].t < cyc);
    mfull = (mq.size() == DEPTH);
    if (vd && mfull) movf = 1'b1;
    else if (clr)    movf = 1'b0;
    if (re && vis) void'(mq.pop_front());
    cyc++;
    if (vd && !mfull) begin
      mq.push_back('{d: d, t: cyc, last: ((nacc % WB) == WB - 1)});
      nacc++;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic model_clear();
    mq.delete();
    movf = 1'b0;
    nacc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rd_fifo_vd = 1'b0;
    bus.rd_en      = 1'b0;
    bus.ovf_clr    = 1'b0;
    bus.rd_fifo_in = '0;
    model_clear();
    @(posedge clk);
    #1;
    check_model();
    chk("rst_rd_fifo_out", bus.rd_fifo_out, 0);
    chk("rst_out_last",    bus.fifo_out_last, 0);
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int expi;
    reset = 1'b1;
    bus.rd_fifo_vd = 1'b0;
    bus.rd_en      = 1'b0;
    bus.ovf_clr    = 1'b0;
    bus.rd_fifo_in = '0;
    repeat (3) @(posedge clk);
    #1;

    // 1: reset state, idle cycle, then async reset between edges
    do_reset();
    step(0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'(100 + i));
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_model();
    chk("async_rst_count", bus.data_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 2: single beat, one-cycle fall-through latency
    do_reset();
    step(1, 0, 0, DW'('hA5));
    chk("single_vd_early", bus.fifo_out_vd, 0);
    step(0, 0, 0, '0);
    chk("single_vd",    bus.fifo_out_vd,  1);
    chk("single_data",  bus.rd_fifo_out,  DW'('hA5));
    chk("single_count", bus.data_count,   1);
    chk("single_empty", bus.empty,        0);
    chk("single_ae",    bus.almost_empty, 1);

    // 3: two bursts streamed through with rd_en held high
    do_reset();
    expi = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 16, 1, 0, DW'(i));
      if (bus.fifo_out_vd) begin
        chk("seq_data", bus.rd_fifo_out, DW'(expi));
        chk("seq_last", bus.fifo_out_last, (expi == 7) || (expi == 15));
        expi++;
      end
    end
    chk("seq_total", expi, 16);

    // 4 + 5: fill to full, drop, pop-with-write at full, then clear overflow
    for (int i = 0; i < 16; i++)
      tbl[i] = '{vd: 1, re: 0, clr: 0, cnt: 5'(i + 1), full: (i + 1 == 16),
                 af: (i + 1 >= 12), br: (i + 1 <= 8), ovf: 0};
    tbl[16] = '{vd: 1, re: 0, clr: 0, cnt: 16, full: 1, af: 1, br: 0, ovf: 1};
    tbl[17] = '{vd: 1, re: 1, clr: 0, cnt: 15, full: 0, af: 1, br: 0, ovf: 1};
    tbl[18] = '{vd: 0, re: 0, clr: 1, cnt: 15, full: 0, af: 1, br: 0, ovf: 0};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].vd, tbl[i].re, tbl[i].clr, DW'(i));
      chk("tbl_count",      bus.data_count,  tbl[i].cnt);
      chk("tbl_full",       bus.full,        tbl[i].full);
      chk("tbl_af",         bus.almost_full, tbl[i].af);
      chk("tbl_burst_room", bus.burst_room,  tbl[i].br);
      chk("tbl_overflow",   bus.overflow,    tbl[i].ovf);
    end

    // 6: steady push+pop at count 5 across pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, rnd128());
    step(0, 0, 0, '0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, rnd128());
      chk("steady_count", bus.data_count, 5);
      chk("steady_vd",    bus.fifo_out_vd, 1);
    end

    // Random traffic: fill-heavy phase then drain-heavy phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < ((i < 300) ? 35 : 80),
           $urandom_range(0, 99) < 5,
           rnd128());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
